// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared fetch-stage types and constants for the MIPS pipeline
package pipeline_pkg;
    typedef enum logic [1:0] {FETCH, HELD, DISCARD} fetch_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int PC_STEP = 4;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline register holding valid/instr/pc4 with flush > hold > load
// Ports: clk, rst_n (async active-low), flush (bubble), hold (freeze), load (capture instr_d/pc4_d),
//        valid/instr/pc4 (registered outputs; instr is NOP when not valid)
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               hold,
    input  logic               load,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [ADDR_W-1:0]  pc4_d,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc4
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= INSTR_W'(NOP_INSTR);
            pc4   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= INSTR_W'(NOP_INSTR);
        end else if (!hold) begin
            valid <= load;
            instr <= load ? instr_d : INSTR_W'(NOP_INSTR);
            if (load) pc4 <= pc4_d;
        end
endmodule

// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: PC, imem handshake and IF/ID control honouring holdPC, IF_ID_Flush and branches
// Ports: clk, rst_n (async active-low); holdPC, IF_ID_Flush, branch_taken, branch_target (hazard ctrl);
//        imem_req/imem_addr out, imem_ready/imem_rdata in (instruction memory);
//        if_id_valid/if_id_instr/if_id_pc4 (decode-stage register); stall_cnt (saturating hold count)
module fetch_stage_ctrl
    import pipeline_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               holdPC,
    input  logic               IF_ID_Flush,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc4,
    output logic [CNT_W-1:0]   stall_cnt
);
    fetch_state_t       state, state_nx;
    logic [ADDR_W-1:0]  pc, pc_nx, pc4, tgt, tgt_nx;
    logic [INSTR_W-1:0] skid_instr, cap_instr;
    logic               req_en, rdy, cap, skid_ld;

    // In HELD the PC is frozen, so the parked instruction's PC+4 is simply pc4.
    assign pc4       = pc + ADDR_W'(PC_STEP);
    assign imem_req  = req_en && state != HELD;
    assign imem_addr = pc;
    assign rdy       = imem_req && imem_ready;

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        tgt_nx    = tgt;
        skid_ld   = 1'b0;
        cap       = 1'b0;
        cap_instr = imem_rdata;
        case (state)
            FETCH:
                if (branch_taken) begin
                    if (rdy) pc_nx = branch_target;
                    else begin
                        tgt_nx   = branch_target;
                        state_nx = DISCARD;
                    end
                end else if (rdy) begin
                    if (holdPC) begin
                        skid_ld  = 1'b1;
                        state_nx = HELD;
                    end else begin
                        pc_nx = pc4;
                        cap   = !IF_ID_Flush;
                    end
                end
            HELD: begin
                cap_instr = skid_instr;
                if (branch_taken) begin
                    pc_nx    = branch_target;
                    state_nx = FETCH;
                end else if (!holdPC) begin
                    pc_nx    = pc4;
                    cap      = !IF_ID_Flush;
                    state_nx = FETCH;
                end
            end
            DISCARD: begin
                if (branch_taken) tgt_nx = branch_target;
                if (rdy) begin
                    pc_nx    = tgt_nx;
                    state_nx = FETCH;
                end
            end
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            tgt        <= '0;
            skid_instr <= INSTR_W'(NOP_INSTR);
            req_en     <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            tgt    <= tgt_nx;
            req_en <= 1'b1;
            if (skid_ld) skid_instr <= imem_rdata;
            if (holdPC && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end

    if_id_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (branch_taken || IF_ID_Flush),
        .hold    (holdPC),
        .load    (cap),
        .instr_d (cap_instr),
        .pc4_d   (pc4),
        .valid   (if_id_valid),
        .instr   (if_id_instr),
        .pc4     (if_id_pc4)
    );
endmodule
